// File: rtl/icode_pkg.sv
// Shared definitions for the instruction fetch slice.
//   ADDR_W / DATA_W    : program-memory address and instruction byte widths
//   HALT_CODE_DEFAULT  : opcode that ends a fetch run
//   state_t            : fetch controller states
package icode_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] HALT_CODE_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/icode_fifo.sv
// Show-ahead prefetch FIFO for instruction bytes.
//   clk, rst (async, active-low)
//   push/din   : write one byte (ignored when full)
//   pop        : consume head byte (ignored when empty)
//   flush      : discard all contents; wins over push/pop in the same cycle
//   dout       : current head byte, 0 while empty
//   count      : number of stored bytes (0..DEPTH)
//   empty      : no byte stored
module icode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;

  // Head is read combinationally so the consumer sees the byte in the same
  // cycle it becomes valid; the empty gate keeps the output at 0 otherwise.
  assign dout = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/icode_fetch.sv
// Instruction prefetch unit: reads program memory ahead of the processor
// and buffers bytes in a small FIFO.
//   clk, rst (async, active-low)
//   start/start_addr  : begin fetching (IDLE), or leave HALT loading pc
//   jmp_en/jmp_addr   : flush buffered/in-flight bytes and reload pc
//   stop              : stop issuing reads; buffered bytes stay deliverable
//   pmem_en/pmem_addr : read request, data on pmem_rdata one cycle later
//   ICODE/icode_valid/icode_ready : byte stream to the processor
//   busy              : fetching or bytes still buffered
//   pc                : next address to be issued
module icode_fetch
  import icode_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter logic [DATA_W-1:0] HALT_CODE = HALT_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              stop,
  output logic              pmem_en,
  output logic [ADDR_W-1:0] pmem_addr,
  input  logic [DATA_W-1:0] pmem_rdata,
  output logic [DATA_W-1:0] ICODE,
  output logic              icode_valid,
  input  logic              icode_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              pmem_en_reg, pmem_en_next;
  logic [ADDR_W-1:0] pmem_addr_reg, pmem_addr_next;
  // rvalid_reg marks that pmem_rdata carries the answer to last cycle's read.
  logic              rvalid_reg, rvalid_next;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [CW:0]       occupancy;
  logic              can_issue;
  logic              halt_write;

  icode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rvalid_reg),
    .din   (pmem_rdata),
    .pop   (icode_ready),
    .flush (jmp_en),
    .dout  (ICODE),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Both the read presented this cycle and the data on the bus will land in
  // the FIFO, so they reserve slots. A pop this cycle is deliberately not
  // credited: it costs at most one idle slot and keeps the check simple.
  assign occupancy  = {1'b0, fifo_count} + (CW+1)'(pmem_en_reg) + (CW+1)'(rvalid_reg);
  assign can_issue  = occupancy < (CW+1)'(DEPTH);
  assign halt_write = rvalid_reg && (pmem_rdata == HALT_CODE) && (state_reg == ST_FETCH);

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    pmem_en_next   = 1'b0;
    pmem_addr_next = pmem_addr_reg;
    rvalid_next    = pmem_en_reg;

    if (jmp_en) begin
      // Redirect wins over everything: the read the memory captures at this
      // edge is thrown away, and FETCH re-issues from jmp_addr next cycle.
      pc_next     = jmp_addr;
      rvalid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !stop) begin
            state_next     = ST_FETCH;
            pmem_en_next   = 1'b1;
            pmem_addr_next = start_addr;
            pc_next        = start_addr + 8'd1;
          end
        end
        ST_FETCH: begin
          if (stop) begin
            // Outstanding read still completes via rvalid_next.
            state_next = ST_IDLE;
          end else if (halt_write) begin
            state_next  = ST_HALT;
            rvalid_next = 1'b0;
          end else if (can_issue) begin
            pmem_en_next   = 1'b1;
            pmem_addr_next = pc_reg;
            pc_next        = pc_reg + 8'd1;
          end
        end
        ST_HALT: begin
          if (start && !stop) begin
            state_next = ST_IDLE;
            pc_next    = start_addr;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      pmem_en_reg   <= 1'b0;
      pmem_addr_reg <= '0;
      rvalid_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pmem_en_reg   <= pmem_en_next;
      pmem_addr_reg <= pmem_addr_next;
      rvalid_reg    <= rvalid_next;
    end
  end

  assign pmem_en     = pmem_en_reg;
  assign pmem_addr   = pmem_addr_reg;
  assign pc          = pc_reg;
  assign icode_valid = !fifo_empty;
  assign busy        = (state_reg == ST_FETCH) || !fifo_empty;

endmodule
